// File: rtl/vram_pkg.sv
// Shared types and default widths for the graphics-memory port arbiter.
package vram_pkg;

  localparam int VRAM_ADDR_W = 11;
  localparam int VRAM_DATA_W = 32;

  // Which requester owns the memory port in the current cycle.
  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_READ  = 2'd1,
    GNT_WRITE = 2'd2
  } grant_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Host write buffer: DEPTH entries of WIDTH bits, extra-bit pointers for
// full/empty detection, head visible combinationally (no fall-through of
// a push into the same cycle's head).
module vram_wr_fifo #(
  parameter int WIDTH = 43,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]     wr_ptr_r;
  logic [PTR_W:0]     rd_ptr_r;
  logic [WIDTH-1:0]   store_r [DEPTH];
  logic               push_ok_s;
  logic               pop_ok_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                     (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head_data = store_r[rd_ptr_r[PTR_W-1:0]];

  // Advance write/read pointers; both may move in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {(PTR_W+1){1'b0}};
      rd_ptr_r <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + (PTR_W+1)'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + (PTR_W+1)'(1);
      end
    end
  end

  // Capture pushed entries; contents need no reset since pointers gate use.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      store_r[wr_ptr_r[PTR_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/vram_port_arbiter.sv
// Arbitrates one single-port graphics memory between buffered host writes
// and renderer reads. Reads win unless a queued write has been held off
// for STARVE_LIMIT consecutive read grants, in which case one write slot
// is forced. Read data returns one cycle after the grant.
module vram_port_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W       = VRAM_ADDR_W,
  parameter int DATA_W       = VRAM_DATA_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic [ADDR_W+DATA_W-1:0] fifo_head_s;
  logic [ADDR_W-1:0]        head_addr_s;
  logic [DATA_W-1:0]        head_data_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     forced_s;
  grant_t                   grant_s;
  logic [CNT_W-1:0]         starve_cnt_r;
  logic                     rd_valid_r;
  logic [ADDR_W-1:0]        last_addr_r;

  assign host_wr_ready = !reset && !fifo_full_s;
  assign push_s        = host_wr_valid && host_wr_ready;
  assign pop_s         = (grant_s == GNT_WRITE);
  assign head_addr_s   = fifo_head_s[ADDR_W+DATA_W-1:DATA_W];
  assign head_data_s   = fifo_head_s[DATA_W-1:0];
  assign forced_s      = (starve_cnt_r == CNT_MAX) && !fifo_empty_s;

  vram_wr_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data ({host_addr, host_data}),
    .pop       (pop_s),
    .head_data (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Pick the owner of this cycle's memory slot.
  always_comb begin
    grant_s = GNT_IDLE;
    if (reset) begin
      grant_s = GNT_IDLE;
    end else if (rd_req && !forced_s) begin
      grant_s = GNT_READ;
    end else if (!fifo_empty_s) begin
      grant_s = GNT_WRITE;
    end else begin
      grant_s = GNT_IDLE;
    end
  end

  // Drive the memory port and the read handshake from the grant.
  always_comb begin
    rd_ready  = 1'b0;
    mem_rw    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    case (grant_s)
      GNT_READ: begin
        rd_ready = 1'b1;
        mem_addr = rd_addr;
      end
      GNT_WRITE: begin
        mem_rw    = 1'b1;
        mem_addr  = head_addr_s;
        mem_wdata = head_data_s;
      end
      GNT_IDLE: begin
        if (reset) begin
          mem_addr = {ADDR_W{1'b0}};
        end else begin
          mem_addr = last_addr_r;
        end
      end
      default: begin
        mem_addr = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Count read grants that overtake a waiting write; saturate at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if ((grant_s == GNT_WRITE) || fifo_empty_s) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if ((grant_s == GNT_READ) && (starve_cnt_r != CNT_MAX)) begin
      starve_cnt_r <= starve_cnt_r + CNT_W'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Flag that the memory's registered read data belongs to a granted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= (grant_s == GNT_READ);
    end
  end

  // Remember the last driven address so idle cycles keep the bus stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_addr_r <= {ADDR_W{1'b0}};
    end else begin
      last_addr_r <= mem_addr;
    end
  end

  // A read in flight when reset arrives must not surface.
  assign rd_valid = rd_valid_r && !reset;
  assign rd_data  = rd_valid ? mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Scoreboard bench for vram_port_arbiter: a queue-based reference model
// predicts each cycle's grant, the write drain order and read data; a
// separate monitor compares DUT outputs against those expectations.
module tb_vram_port_arbiter;

  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LIM   = 8;
  localparam int MEMN  = 2048;

  logic          clk;
  logic          reset;
  logic          host_wr_valid;
  logic          host_wr_ready;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  vram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .reset(reset),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_addr(host_addr), .host_data(host_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expectation records.
  typedef struct { int grant; bit ready; logic [AW-1:0] addr; logic [DW-1:0] wdata; } cyc_exp_t;
  typedef struct { int due; logic [DW-1:0] data; } rd_exp_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;

  cyc_exp_t expq[$];
  rd_exp_t  rdq[$];
  wr_t      wsb[$];
  wr_t      mq[$];
  logic [DW-1:0] mmem   [MEMN];
  logic [DW-1:0] hw_mem [MEMN];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wait_cnt = 0;
  logic [AW-1:0] last_addr = '0;

  // Simple single-port memory: registered read data, untouched by writes.
  always @(posedge clk) begin
    if (mem_rw) hw_mem[mem_addr] <= mem_wdata;
    else        mem_rdata <= hw_mem[mem_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One cycle of stimulus plus reference-model update.
  task automatic step(input bit rst, input bit req, input logic [AW-1:0] ra,
                      input bit hv, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                      output bit granted, output bit pushed);
    cyc_exp_t e;
    wr_t w;
    bit rdy;
    bit forced;
    @(posedge clk);
    #1;
    cyc++;
    reset = rst; rd_req = req; rd_addr = ra;
    host_wr_valid = hv; host_addr = ha; host_data = hd;
    granted = 1'b0;
    pushed  = 1'b0;
    if (rst) begin
      e = '{0, 1'b0, '0, '0};
      mq.delete(); wsb.delete(); rdq.delete();
      wait_cnt = 0;
      last_addr = '0;
    end else begin
      rdy    = (mq.size() < DEPTH);
      forced = (mq.size() > 0) && (wait_cnt >= LIM);
      if (req && !forced) begin
        granted = 1'b1;
        rdq.push_back('{cyc + 1, mmem[ra]});
        e = '{1, rdy, ra, '0};
        last_addr = ra;
        if (mq.size() > 0) wait_cnt = (wait_cnt < LIM) ? wait_cnt + 1 : LIM;
        else               wait_cnt = 0;
      end else if (mq.size() > 0) begin
        w = mq.pop_front();
        mmem[w.addr] = w.data;
        e = '{2, rdy, w.addr, w.data};
        last_addr = w.addr;
        wait_cnt = 0;
      end else begin
        e = '{0, rdy, last_addr, '0};
        wait_cnt = 0;
      end
      if (hv && rdy) begin
        pushed = 1'b1;
        mq.push_back('{ha, hd});
        wsb.push_back('{ha, hd});
      end
    end
    expq.push_back(e);
  endtask

  // Monitor: compare outputs against expectations once inputs have settled.
  cyc_exp_t mon_e;
  wr_t      mon_w;
  rd_exp_t  mon_r;
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (expq.size() > 0) begin
        mon_e = expq.pop_front();
        chk("rd_ready", rd_ready, mon_e.grant == 1);
        chk("mem_rw", mem_rw, mon_e.grant == 2);
        chk("host_wr_ready", host_wr_ready, mon_e.ready);
        chk("mem_addr", mem_addr, mon_e.addr);
        if (mon_e.grant != 1) chk("mem_wdata", mem_wdata, mon_e.wdata);
        if (mem_rw) begin
          if (wsb.size() > 0) begin
            mon_w = wsb.pop_front();
            chk("wr_order_addr", mem_addr, mon_w.addr);
            chk("wr_order_data", mem_wdata, mon_w.data);
          end else begin
            chk("unexpected_write", mem_rw, 1'b0);
          end
        end
      end
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        mon_r = rdq.pop_front();
        chk("rd_valid", rd_valid, 1'b1);
        if (rd_valid) chk("rd_data", rd_data, mon_r.data);
      end else begin
        chk("rd_valid_quiet", rd_valid, 1'b0);
      end
    end
  end

  bit g, p;
  bit rpend;
  logic [AW-1:0] raddr;
  int npush;

  initial begin
    reset = 1'b1; rd_req = 1'b0; rd_addr = '0;
    host_wr_valid = 1'b0; host_addr = '0; host_data = '0;
    for (int i = 0; i < MEMN; i++) begin
      mmem[i]   = $urandom;
      hw_mem[i] = mmem[i];
    end
    mmem[3] = 32'h0000_0011;
    hw_mem[3] = 32'h0000_0011;

    // Reset then idle.
    repeat (2) step(1'b1, 1'b0, '0, 1'b0, '0, '0, g, p);
    repeat (3) step(1'b0, 1'b0, '0, 1'b0, '0, '0, g, p);

    // Single host write, then read it back.
    step(1'b0, 1'b0, '0, 1'b1, 11'd7, 32'hDEAD_BEEF, g, p);
    repeat (2) step(1'b0, 1'b0, '0, 1'b0, '0, '0, g, p);
    step(1'b0, 1'b1, 11'd7, 1'b0, '0, '0, g, p);
    repeat (2) step(1'b0, 1'b0, '0, 1'b0, '0, '0, g, p);

    // Five pushes against a continuous read stream.
    npush = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b1, 11'(16 + (i % 16)), npush < 5, 11'(100 + npush),
           32'(32'hA000_0000 + npush), g, p);
      if (p) npush++;
    end
    repeat (8) step(1'b0, 1'b0, '0, 1'b0, '0, '0, g, p);

    // Queued write to addr 3 overtaken by reads until forced.
    step(1'b0, 1'b1, 11'd3, 1'b1, 11'd3, 32'h0000_0022, g, p);
    repeat (20) step(1'b0, 1'b1, 11'd3, 1'b0, '0, '0, g, p);
    repeat (2) step(1'b0, 1'b0, '0, 1'b0, '0, '0, g, p);

    // Reset with three writes queued and reads in flight.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 11'd50, 1'b1, 11'(40 + i), 32'(32'hBAD0_0000 + i), g, p);
    step(1'b1, 1'b1, 11'd50, 1'b0, '0, '0, g, p);
    repeat (2) step(1'b0, 1'b0, '0, 1'b0, '0, '0, g, p);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 11'(40 + i), 1'b0, '0, '0, g, p);
    repeat (2) step(1'b0, 1'b0, '0, 1'b0, '0, '0, g, p);

    // Randomized traffic with occasional resets.
    rpend = 1'b0;
    raddr = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!rpend && ($urandom % 4 != 0)) begin
        rpend = 1'b1;
        raddr = 11'($urandom % 16);
      end
      step(($urandom % 300) == 0, rpend, raddr, 1'($urandom % 2),
           11'($urandom % 16), $urandom, g, p);
      if (g) rpend = 1'b0;
    end

    repeat (20) step(1'b0, 1'b0, '0, 1'b0, '0, '0, g, p);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("reads_drained", 64'(rdq.size()), 64'd0);
    chk("writes_drained", 64'(wsb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
